// File: rtl/uart_pkg.sv
// Shared UART receive definitions: clock/baud defaults, bit-timing derivation and rx FSM states.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

    localparam int unsigned CLK_FREQ_DEFAULT  = 32'd100_000_000;
    localparam int unsigned BAUD_RATE_DEFAULT = 32'd9600;

    function automatic int unsigned calc_divider(input int unsigned clk_freq,
                                                 input int unsigned baud_rate);
        return clk_freq / baud_rate;
    endfunction

    function automatic int unsigned calc_half(input int unsigned divider);
        return divider / 32'd2;
    endfunction

    // Even parity: the transmitted parity bit makes the total count of ones even.
    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO for the UART receiver; pop is applied before push
// so a full FIFO can accept a byte in the same cycle it is read. All outputs are registered.
module uart_rx_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] data,
    output logic       full,
    output logic       empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [7:0]    mem_r [DEPTH];
    logic [AW:0]   wr_ptr_r;
    logic [AW:0]   rd_ptr_r;
    logic [AW:0]   wr_ptr_nxt;
    logic [AW:0]   rd_ptr_nxt;
    logic          pop_ok_s;
    logic          push_ok_s;
    logic          empty_nxt;
    logic          full_nxt;
    logic [7:0]    data_nxt;
    logic [AW-1:0] wr_idx_s;
    logic [AW-1:0] rd_idx_nxt_s;

    assign wr_idx_s = wr_ptr_r[AW-1:0];

    // Next pointers and next registered head/flags; pops take effect before pushes.
    always_comb begin
        pop_ok_s     = pop & ~empty;
        push_ok_s    = push & (~full | pop_ok_s);
        wr_ptr_nxt   = wr_ptr_r + {{AW{1'b0}}, push_ok_s};
        rd_ptr_nxt   = rd_ptr_r + {{AW{1'b0}}, pop_ok_s};
        rd_idx_nxt_s = rd_ptr_nxt[AW-1:0];
        empty_nxt    = (wr_ptr_nxt == rd_ptr_nxt);
        full_nxt     = (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]) &&
                       (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);
        data_nxt     = 8'h00;
        if (empty_nxt) begin
            data_nxt = 8'h00;
        end else if (push_ok_s && (wr_idx_s == rd_idx_nxt_s)) begin
            // The new head is the byte being written this cycle.
            data_nxt = push_data;
        end else begin
            data_nxt = mem_r[rd_idx_nxt_s];
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_r[i] <= 8'h00;
            end
        end else if (push_ok_s) begin
            mem_r[wr_idx_s] <= push_data;
        end
    end

    // Pointer and registered output update.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            data     <= 8'h00;
            full     <= 1'b0;
            empty    <= 1'b1;
        end else begin
            wr_ptr_r <= wr_ptr_nxt;
            rd_ptr_r <= rd_ptr_nxt;
            data     <= data_nxt;
            full     <= full_nxt;
            empty    <= empty_nxt;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver: line synchronizer, mid-bit sampling FSM, sticky error flags and byte FIFO.
// Define UART_RX_PARITY_EN to expect an even-parity bit and expose parity_err.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = CLK_FREQ_DEFAULT,
    parameter int unsigned BAUD_RATE  = BAUD_RATE_DEFAULT,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    input  logic       rd_en,
    input  logic       clr_err,
    output logic [7:0] rx_data,
    output logic       rx_empty,
    output logic       rx_full,
    output logic       frame_err,
    output logic       overrun
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_err
`endif
);

    localparam int unsigned DIVIDER = calc_divider(CLK_FREQ, BAUD_RATE);
    localparam int unsigned HALF    = calc_half(DIVIDER);
    localparam int          CNT_W   = (DIVIDER > 32'd1) ? $clog2(DIVIDER) : 1;
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIVIDER - 32'd1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 32'd1);

    logic [1:0]       sync_r;
    logic             rx_prev_r;
    logic             rx_s;
    logic             fall_s;

    rx_state_e        state_r;
    rx_state_e        state_nxt;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt;
    logic [2:0]       bit_cnt_r;
    logic [2:0]       bit_cnt_nxt;
    logic [7:0]       shift_r;
    logic [7:0]       shift_nxt;
    logic             stop_wait_r;
    logic             stop_wait_nxt;
    logic             push_nxt;
    logic             push_r;
    logic [7:0]       push_data_r;
    logic             ferr_evt_s;
    logic             ovr_evt_s;
`ifdef UART_RX_PARITY_EN
    logic             par_bad_r;
    logic             par_bad_nxt;
    logic             perr_evt_s;
    logic             parity_err_r;
`endif

    assign rx_s   = sync_r[1];
    assign fall_s = rx_prev_r & ~rx_s;

    // Two-flop synchronizer plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r    <= 2'b11;
            rx_prev_r <= 1'b1;
        end else begin
            sync_r    <= {sync_r[0], uart_rx};
            rx_prev_r <= sync_r[1];
        end
    end

    // Receive FSM next-state, bit timing and shift logic.
    always_comb begin
        state_nxt     = state_r;
        cnt_nxt       = cnt_r;
        bit_cnt_nxt   = bit_cnt_r;
        shift_nxt     = shift_r;
        stop_wait_nxt = stop_wait_r;
        push_nxt      = 1'b0;
        ferr_evt_s    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_nxt   = par_bad_r;
        perr_evt_s    = 1'b0;
`endif
        case (state_r)
            ST_IDLE: begin
                if (fall_s) begin
                    state_nxt     = ST_START;
                    cnt_nxt       = '0;
                    bit_cnt_nxt   = 3'd0;
                    stop_wait_nxt = 1'b0;
`ifdef UART_RX_PARITY_EN
                    par_bad_nxt   = 1'b0;
`endif
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_r == HALF_LAST) begin
                    cnt_nxt = '0;
                    // A line already back high at mid-start is a glitch, not a frame.
                    if (rx_s) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt = ST_DATA;
                    end
                end else begin
                    cnt_nxt = cnt_r + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (cnt_r == DIV_LAST) begin
                    cnt_nxt   = '0;
                    shift_nxt = {rx_s, shift_r[7:1]};
                    if (bit_cnt_r == 3'd7) begin
                        bit_cnt_nxt = 3'd0;
`ifdef UART_RX_PARITY_EN
                        state_nxt   = ST_PARITY;
`else
                        state_nxt   = ST_STOP;
`endif
                    end else begin
                        bit_cnt_nxt = bit_cnt_r + 3'd1;
                    end
                end else begin
                    cnt_nxt = cnt_r + CNT_W'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (cnt_r == DIV_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_STOP;
                    if (rx_s != even_parity(shift_r)) begin
                        par_bad_nxt = 1'b1;
                        perr_evt_s  = 1'b1;
                    end else begin
                        par_bad_nxt = 1'b0;
                    end
                end else begin
                    cnt_nxt = cnt_r + CNT_W'(1);
                end
            end
`endif
            ST_STOP: begin
                if (stop_wait_r) begin
                    // Broken frame: hold here until the line recovers to idle.
                    if (rx_s) begin
                        state_nxt     = ST_IDLE;
                        stop_wait_nxt = 1'b0;
                    end else begin
                        state_nxt = ST_STOP;
                    end
                end else if (cnt_r == DIV_LAST) begin
                    cnt_nxt = '0;
                    if (rx_s) begin
                        state_nxt = ST_IDLE;
`ifdef UART_RX_PARITY_EN
                        push_nxt  = ~par_bad_r;
`else
                        push_nxt  = 1'b1;
`endif
                    end else begin
                        ferr_evt_s    = 1'b1;
                        stop_wait_nxt = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_nxt     = ST_IDLE;
                cnt_nxt       = '0;
                bit_cnt_nxt   = 3'd0;
                stop_wait_nxt = 1'b0;
            end
        endcase
    end

    // FSM state and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= '0;
            bit_cnt_r   <= 3'd0;
            shift_r     <= 8'h00;
            stop_wait_r <= 1'b0;
            push_r      <= 1'b0;
            push_data_r <= 8'h00;
`ifdef UART_RX_PARITY_EN
            par_bad_r   <= 1'b0;
`endif
        end else begin
            state_r     <= state_nxt;
            cnt_r       <= cnt_nxt;
            bit_cnt_r   <= bit_cnt_nxt;
            shift_r     <= shift_nxt;
            stop_wait_r <= stop_wait_nxt;
            push_r      <= push_nxt;
            push_data_r <= push_nxt ? shift_r : push_data_r;
`ifdef UART_RX_PARITY_EN
            par_bad_r   <= par_bad_nxt;
`endif
        end
    end

    // A pending push is dropped only when the FIFO is full and not being read.
    assign ovr_evt_s = push_r & rx_full & ~rd_en;

    // Sticky error flags; a new error wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= ferr_evt_s | (frame_err & ~clr_err);
            overrun   <= ovr_evt_s  | (overrun & ~clr_err);
        end
    end

`ifdef UART_RX_PARITY_EN
    // Sticky parity error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_err_r <= 1'b0;
        end else begin
            parity_err_r <= perr_evt_s | (parity_err_r & ~clr_err);
        end
    end

    assign parity_err = parity_err_r;
`endif

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_r),
        .push_data (push_data_r),
        .pop       (rd_en),
        .data      (rx_data),
        .full      (rx_full),
        .empty     (rx_empty)
    );

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: table-driven frames plus hand-written corner sequences,
// with a scoreboard queue of expected bytes compared as the FIFO presents them.
module tb_uart_rx_ctrl;

    localparam int unsigned TB_CLK_FREQ  = 32'd50_000_000;
    localparam int unsigned TB_BAUD_RATE = 32'd1_000_000;
    localparam int          DIV          = 50;
    localparam int          DEPTH        = 4;

    logic       clk;
    logic       rst;
    logic       uart_rx;
    logic       rd_en;
    logic       clr_err;
    logic [7:0] rx_data;
    logic       rx_empty;
    logic       rx_full;
    logic       frame_err;
    logic       overrun;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int         n_vec;
    int         n_err;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] data;
        logic       stop_lvl;
        logic       exp_push;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs[7];

    uart_rx_ctrl #(
        .CLK_FREQ   (TB_CLK_FREQ),
        .BAUD_RATE  (TB_BAUD_RATE),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .uart_rx   (uart_rx),
        .rd_en     (rd_en),
        .clr_err   (clr_err),
        .rx_data   (rx_data),
        .rx_empty  (rx_empty),
        .rx_full   (rx_full),
        .frame_err (frame_err),
        .overrun   (overrun)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tx_bit(input logic b);
        uart_rx = b;
        repeat (DIV) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop_lvl);
        tx_bit(1'b0);
        for (int i = 0; i < 8; i++) tx_bit(data[i]);
`ifdef UART_RX_PARITY_EN
        tx_bit(^data);
`endif
        tx_bit(stop_lvl);
        uart_rx = 1'b1;
        repeat (2 * DIV) @(negedge clk);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_par_frame(input logic [7:0] data, input logic par_bit);
        tx_bit(1'b0);
        for (int i = 0; i < 8; i++) tx_bit(data[i]);
        tx_bit(par_bit);
        tx_bit(1'b1);
        repeat (2 * DIV) @(negedge clk);
    endtask
`endif

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        @(negedge clk);
    endtask

    // Pop every byte the FIFO presents and compare it against the scoreboard.
    task automatic drain(input string name);
        logic [7:0] e;
        for (int k = 0; k < DEPTH + 2; k++) begin
            if (rx_empty == 1'b0) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL %s_extra: got byte %0h, expected none", name, rx_data);
                end else begin
                    e = exp_q.pop_front();
                    check({name, "_data"}, {24'd0, rx_data}, {24'd0, e});
                end
                rd_en = 1'b1;
                @(negedge clk);
                rd_en = 1'b0;
            end
        end
        check({name, "_missing"}, exp_q.size(), 32'd0);
        check({name, "_empty"}, {31'd0, rx_empty}, 32'd1);
        exp_q.delete();
    endtask

    initial begin
        int cyc;
        n_vec   = 0;
        n_err   = 0;
        rst     = 1'b1;
        uart_rx = 1'b1;
        rd_en   = 1'b0;
        clr_err = 1'b0;

        vecs[0] = '{data: 8'h55, stop_lvl: 1'b1, exp_push: 1'b1, exp_ferr: 1'b0};
        vecs[1] = '{data: 8'h00, stop_lvl: 1'b1, exp_push: 1'b1, exp_ferr: 1'b0};
        vecs[2] = '{data: 8'hFF, stop_lvl: 1'b1, exp_push: 1'b1, exp_ferr: 1'b0};
        vecs[3] = '{data: 8'hA3, stop_lvl: 1'b0, exp_push: 1'b0, exp_ferr: 1'b1};
        vecs[4] = '{data: 8'h3C, stop_lvl: 1'b1, exp_push: 1'b1, exp_ferr: 1'b1};
        vecs[5] = '{data: 8'h81, stop_lvl: 1'b1, exp_push: 1'b1, exp_ferr: 1'b0};
        vecs[6] = '{data: 8'h7E, stop_lvl: 1'b1, exp_push: 1'b1, exp_ferr: 1'b0};

        repeat (4) @(negedge clk);
        check("rst_empty", {31'd0, rx_empty}, 32'd1);
        check("rst_full", {31'd0, rx_full}, 32'd0);
        check("rst_data", {24'd0, rx_data}, 32'd0);
        check("rst_ferr", {31'd0, frame_err}, 32'd0);
        check("rst_ovr", {31'd0, overrun}, 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Latency: 0x55 must reach the FIFO head within 10 bit times + 4 cycles.
        exp_q.push_back(8'h55);
        cyc = 0;
        fork
            send_frame(8'h55, 1'b1);
            begin
                while (rx_empty && cyc < 10 * DIV + 4) begin
                    @(negedge clk);
                    cyc++;
                end
                check("lat_ready", {31'd0, rx_empty}, 32'd0);
            end
        join
        drain("lat");

        // Table: vector 3 breaks the stop bit, vector 4 follows with the error still sticky.
        for (int v = 0; v < 7; v++) begin
            if (vecs[v].exp_push) exp_q.push_back(vecs[v].data);
            send_frame(vecs[v].data, vecs[v].stop_lvl);
            check($sformatf("v%0d_ferr", v), {31'd0, frame_err}, {31'd0, vecs[v].exp_ferr});
            check($sformatf("v%0d_empty", v), {31'd0, rx_empty}, {31'd0, ~vecs[v].exp_push});
            drain($sformatf("v%0d", v));
            if (vecs[v].exp_ferr && vecs[v].exp_push) begin
                pulse_clr();
                check($sformatf("v%0d_clr", v), {31'd0, frame_err}, 32'd0);
            end
        end

        // Overrun: five bytes into a four-deep FIFO; the fifth is dropped.
        for (int b = 1; b <= 5; b++) begin
            if (b <= DEPTH) exp_q.push_back(8'(b));
            send_frame(8'(b), 1'b1);
        end
        check("ovr_full", {31'd0, rx_full}, 32'd1);
        check("ovr_flag", {31'd0, overrun}, 32'd1);
        check("ovr_ferr", {31'd0, frame_err}, 32'd0);
        drain("ovr");
        check("ovr_full_after", {31'd0, rx_full}, 32'd0);
        pulse_clr();
        check("ovr_clr", {31'd0, overrun}, 32'd0);

        // Short low glitch shorter than half a bit is rejected.
        uart_rx = 1'b0;
        repeat (10) @(negedge clk);
        uart_rx = 1'b1;
        repeat (12 * DIV) @(negedge clk);
        check("glitch_empty", {31'd0, rx_empty}, 32'd1);
        check("glitch_ferr", {31'd0, frame_err}, 32'd0);
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 1'b1);
        drain("glitch");

        // Reset during data bit 4 of 0xFF abandons the frame.
        fork
            send_frame(8'hFF, 1'b1);
            begin
                repeat (5 * DIV + DIV / 2) @(negedge clk);
                rst = 1'b1;
                repeat (2) @(negedge clk);
                rst = 1'b0;
            end
        join
        check("rstmid_empty", {31'd0, rx_empty}, 32'd1);
        check("rstmid_ferr", {31'd0, frame_err}, 32'd0);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1);
        drain("rstmid");

`ifdef UART_RX_PARITY_EN
        send_par_frame(8'h07, 1'b0);
        check("par_bad_flag", {31'd0, parity_err}, 32'd1);
        check("par_bad_empty", {31'd0, rx_empty}, 32'd1);
        check("par_bad_ferr", {31'd0, frame_err}, 32'd0);
        exp_q.push_back(8'h07);
        send_par_frame(8'h07, 1'b1);
        drain("par_ok");
        pulse_clr();
        check("par_clr", {31'd0, parity_err}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 Parameter: CLK_FREQ, default 100_000_000, system clock frequency in Hz.
REQ-002 Parameter: BAUD_RATE, default 9600, serial bit rate.
REQ-003 Parameter: FIFO_DEPTH, default 4, received-byte buffer depth; power of two, at least 2.
REQ-004 Port: clk  in  1  system clock; one clock; all logic on rising edge.
REQ-005 Port: rst  in  1  reset, synchronous, active-high.
REQ-006 Port: uart_rx  in  1  asynchronous serial line; idles high.
REQ-007 Port: rd_en  in  1  pop request for the head byte of the FIFO.
REQ-008 Port: clr_err  in  1  one-cycle pulse that clears the sticky error flags.
REQ-009 Port: rx_data  out  8  head byte of the FIFO (first-word fall-through); 0x00 when empty.
REQ-010 Port: rx_empty  out  1  FIFO holds no bytes.
REQ-011 Port: rx_full  out  1  FIFO holds FIFO_DEPTH bytes.
REQ-012 Port: frame_err  out  1  sticky; stop bit sampled low.
REQ-013 Port: overrun  out  1  sticky; a good byte was dropped because the FIFO was full.
REQ-014 Port: parity_err  out  1  sticky; present only when UART_RX_PARITY_EN is defined.

Function
REQ-015 uart_rx SHALL pass through a 2-FF synchronizer; all decisions SHALL use the synchronized value.
REQ-016 DIVIDER SHALL equal CLK_FREQ/BAUD_RATE using integer division (10416 at the defaults); HALF SHALL equal DIVIDER/2 (5208).
REQ-017 FSM states SHALL be IDLE, START, DATA, PARITY (macro only) and STOP.
REQ-018 IDLE: a synchronized high-to-low transition SHALL move the FSM to START and clear the bit counter.
REQ-019 START: after HALF cycles the line SHALL be sampled; a high sample is treated as a glitch and returns the FSM to IDLE with no flag set, otherwise the FSM goes to DATA.
REQ-020 DATA: the line SHALL be sampled every DIVIDER cycles, 8 bits, LSB first, shifting into an 8-bit register; after bit 7 the FSM SHALL go to STOP, or to PARITY when the macro is defined.
REQ-021 STOP: the line SHALL be sampled DIVIDER cycles after the last data or parity sample.
- High sample: the byte is pushed and the FSM returns to IDLE.
- Low sample: frame_err is set, the byte is discarded, and the FSM stays in STOP until the line is high, then goes to IDLE.
REQ-022 A push SHALL write the FIFO on the cycle after the stop sample; rx_empty SHALL deassert on the following cycle.
REQ-023 Push while full with no pop: the byte SHALL be dropped, overrun set, and FIFO contents left unchanged.
REQ-024 Push and pop in the same cycle: the pop SHALL be applied first, so a push while full with rd_en asserted succeeds and overrun is not set.
REQ-025 rd_en while empty SHALL be ignored, with no pointer change.
REQ-026 FIFO pointers SHALL be log2(FIFO_DEPTH)+1 bits wide and wrap modulo 2*FIFO_DEPTH; full and empty SHALL be derived from the pointer MSB and the remaining bits.
REQ-027 clr_err SHALL clear all sticky flags; if clr_err and a new error occur in the same cycle, the flag SHALL end up set.

Reset
REQ-028 rst SHALL force the following on the next clock edge:
- FSM to IDLE; counters and shift register to 0;
- FIFO to empty (rx_empty=1, rx_full=0, rx_data=0x00);
- all error flags to 0;
- synchronizer flops to 1.
REQ-029 rst asserted mid-frame SHALL abandon the frame with no push and no flag set; reception SHALL resume at the next falling edge after rst deasserts.

Configuration
REQ-030 Macro UART_RX_PARITY_EN.
- Defined: an even-parity bit is expected after bit 7 and sampled DIVIDER cycles later in the PARITY state. On a mismatch parity_err is set and the byte is discarded, but the stop bit is still checked.
- Undefined: there is no PARITY state and no parity_err port, and a frame is 10 bits.

Structure
REQ-031 Shared package uart_pkg SHALL hold the CLK_FREQ and BAUD_RATE defaults, the DIVIDER/HALF derivation, and the rx state enum typedef.
REQ-032 The FIFO SHALL be a sub-module named uart_rx_fifo (push, pop, data, full, empty); the FSM and sampling logic stay in uart_rx_ctrl.

Verification
REQ-033 Send 0x55 (8N1, 104.16 us/bit) -> rx_data=0x55 and rx_empty=0 within 10*10416+4 cycles of the start edge; rd_en for 1 cycle -> rx_empty=1.
REQ-034 Send 0xA3 with stop bit held low -> frame_err=1, rx_empty stays 1; line returns high, then send 0x3C -> 0x3C received; clr_err -> frame_err=0.
REQ-035 Send 0x01,0x02,0x03,0x04,0x05 without reads (FIFO_DEPTH=4) -> rx_full=1, overrun=1, and reads return 0x01..0x04 in order.
REQ-036 Drive a 2000-cycle low pulse on an idle line -> no push and no flags; a following 0x7E is received correctly.
REQ-037 Assert rst during bit 4 of 0xFF -> no push; after rst is released, 0x81 is received correctly.
REQ-038 With UART_RX_PARITY_EN: send 0x07 with parity bit 0 (wrong) -> parity_err=1, no push; send 0x07 with parity 1 -> 0x07 received.
